cntr_word_unpacker: RTL and testbench

- Consumer end of the packed-counter output stream produced by the Top capture path (data_out / data_out_valid / data_out_read).
- Pulls one 32-bit word at a time with the read handshake and unpacks up to three 10-bit counter samples.
- Re-emits the samples oldest-first on a valid/ready stream for downstream TDOA/correlation logic or the host bridge.
- Counts malformed (empty) words.

---
 rtl/cntr_word_unpacker_pkg.sv | 32 +++
 rtl/cntr_word_unpacker_sat_counter.sv | 33 +++
 rtl/cntr_word_unpacker.sv | 99 +++++++++
 tb/tb_cntr_word_unpacker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_word_unpacker_pkg.sv
// Packed-counter word format shared by the capture-side packer and this unpacker.
package cntr_word_unpacker_pkg;

  localparam int unsigned CNTR_W           = 10;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned SAMPLES_PER_WORD = 3;
  localparam int unsigned CNT_W            = 2;
  localparam int unsigned DROP_W           = 8;

  // Sample i lives at [i*CNTR_W +: CNTR_W]; the count field sits above the last sample.
  localparam int unsigned SAMPLE_LSB0 = 0;
  localparam int unsigned CNT_LSB     = SAMPLES_PER_WORD * CNTR_W;
  localparam int unsigned IDX_W       = CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Number of valid samples carried by a word.
  function automatic logic [CNT_W-1:0] word_count(input logic [WORD_W-1:0] w);
    return CNT_W'(w >> CNT_LSB);
  endfunction

  // Sample field idx of a word (pure bit slice).
  function automatic logic [CNTR_W-1:0] word_sample(input logic [WORD_W-1:0] w,
                                                    input logic [IDX_W-1:0]  idx);
    return CNTR_W'(w >> (SAMPLE_LSB0 + CNTR_W * 32'(idx)));
  endfunction

endpackage

// File: rtl/cntr_word_unpacker_sat_counter.sv
// Saturating up-counter with synchronous clear.
module cntr_word_unpacker_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next value: increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register; clear wins over enable.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cntr_word_unpacker.sv
// Pulls packed counter words and re-emits their samples oldest-first on a valid/ready stream.
module cntr_word_unpacker
  import cntr_word_unpacker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_read,
  output logic [CNTR_W-1:0] cntr_out,
  output logic              cntr_out_valid,
  input  logic              cntr_out_ready,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              drop_pulse
);

  state_e            state_q;
  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              last_c;
  logic              data_in_read_q;
  logic              cntr_out_valid_q;
  logic              drop_pulse_q;
  logic [CNTR_W-1:0] cntr_out_q;

  // Index of the following sample and whether the current one closes the word.
  always_comb begin
    idx_d  = idx_q + IDX_W'(1);
    last_c = (idx_q == IDX_W'(word_count(word_q) - CNT_W'(1)));
  end

  // Unpacking FSM; all outputs registered, the next sample is preloaded on each accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      word_q           <= '0;
      idx_q            <= '0;
      data_in_read_q   <= 1'b0;
      cntr_out_valid_q <= 1'b0;
      drop_pulse_q     <= 1'b0;
      cntr_out_q       <= '0;
    end else begin
      data_in_read_q <= 1'b0;
      drop_pulse_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (data_in_valid) begin
            word_q         <= data_in;
            idx_q          <= '0;
            data_in_read_q <= 1'b1;
            if (word_count(data_in) != '0) begin
              state_q          <= ST_EMIT;
              cntr_out_q       <= word_sample(data_in, '0);
              cntr_out_valid_q <= 1'b1;
            end else begin
              state_q      <= ST_DROP;
              drop_pulse_q <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (cntr_out_ready) begin
            if (last_c) begin
              state_q          <= ST_IDLE;
              cntr_out_valid_q <= 1'b0;
            end else begin
              idx_q      <= idx_d;
              cntr_out_q <= word_sample(word_q, idx_d);
            end
          end
        end
        ST_DROP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q          <= ST_IDLE;
          cntr_out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Empty-word tally; the DROP cycle is exactly the cycle drop_pulse is high.
  cntr_word_unpacker_sat_counter #(
    .W (DROP_W)
  ) u_drop_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (drop_pulse_q),
    .cnt_o (drop_cnt)
  );

  assign data_in_read   = data_in_read_q;
  assign cntr_out       = cntr_out_q;
  assign cntr_out_valid = cntr_out_valid_q;
  assign drop_pulse     = drop_pulse_q;

endmodule

// File: tb/tb_cntr_word_unpacker.sv
// Randomised bench for cntr_word_unpacker against a queue-based word/sample model.
module tb_cntr_word_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        data_in_read;
  logic [9:0]  cntr_out;
  logic        cntr_out_valid;
  logic        cntr_out_ready;
  logic [7:0]  drop_cnt;
  logic        drop_pulse;

  cntr_word_unpacker dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_read   (data_in_read),
    .cntr_out       (cntr_out),
    .cntr_out_valid (cntr_out_valid),
    .cntr_out_ready (cntr_out_ready),
    .drop_cnt       (drop_cnt),
    .drop_pulse     (drop_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] src[$];       // words offered by the source, front = data_in
  logic [9:0]  exp_q[$];     // samples of the acknowledged word still owed
  int          read_cyc[$];
  int          cyc = 0;
  int          model_drop = 0;
  int          n_reads = 0;
  int          n_acc = 0;
  int          n_pulses = 0;
  int          n_valid_cyc = 0;
  int          ready_mode = 0; // 0: always ready, 1: random
  int          gap_mode = 0;   // 1: randomly withhold data_in_valid
  int          stall_left = 0;

  logic        prev_valid = 1'b0;
  logic        prev_acc = 1'b0;
  logic [9:0]  prev_out = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] mk_word(input int c, input int s0, input int s1, input int s2);
    logic [31:0] w;
    w = {2'(c), 10'(s2), 10'(s1), 10'(s0)};
    return w;
  endfunction

  // One clock: score the accept at this edge, advance, check, then drive the next inputs.
  task automatic step();
    logic        pre_rst;
    logic        pre_drop;
    logic        pre_acc;
    logic [31:0] w;
    int          c;
    pre_rst  = rst;
    pre_drop = drop_pulse && !rst;
    pre_acc  = cntr_out_valid && cntr_out_ready && !rst;
    if (pre_acc) begin
      if (exp_q.size() == 0) begin
        check("spurious_accept", 32'(cntr_out), 32'hFFFF_FFFF);
      end else begin
        check("sample", 32'(cntr_out), 32'(exp_q.pop_front()));
        n_acc++;
      end
    end
    prev_valid = cntr_out_valid && !rst;
    prev_acc   = pre_acc;
    prev_out   = cntr_out;

    @(posedge clk);
    #1;
    cyc++;

    if (pre_rst) begin
      exp_q.delete();
      model_drop = 0;
      check("rst_read", 32'(data_in_read), 32'd0);
      check("rst_valid", 32'(cntr_out_valid), 32'd0);
      check("rst_pulse", 32'(drop_pulse), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_cntr_out", 32'(cntr_out), 32'd0);
    end else begin
      if (pre_drop) model_drop = (model_drop == 255) ? 255 : model_drop + 1;
      check("drop_cnt", 32'(drop_cnt), 32'(model_drop));
      if (prev_valid && !prev_acc) begin
        check("hold_valid", 32'(cntr_out_valid), 32'd1);
        check("hold_data", 32'(cntr_out), 32'(prev_out));
      end
      if (cntr_out_valid) n_valid_cyc++;
      if (drop_pulse) n_pulses++;
      if (data_in_read) begin
        n_reads++;
        read_cyc.push_back(cyc);
        if (src.size() == 0) begin
          check("read_without_word", 32'd1, 32'd0);
        end else begin
          w = src.pop_front();
          check("read_while_busy", 32'(exp_q.size()), 32'd0);
          c = int'(w[31:30]);
          if (c == 0) begin
            check("empty_pulse", 32'(drop_pulse), 32'd1);
            check("empty_no_valid", 32'(cntr_out_valid), 32'd0);
          end else begin
            for (int i = 0; i < c; i++) exp_q.push_back(w[i*10 +: 10]);
            check("first_valid", 32'(cntr_out_valid), 32'd1);
            check("first_no_pulse", 32'(drop_pulse), 32'd0);
          end
        end
      end else if (drop_pulse) begin
        check("pulse_without_read", 32'd1, 32'd0);
      end
    end

    data_in_valid = (src.size() != 0) && ((gap_mode == 0) || ($urandom_range(0, 3) != 0));
    data_in       = (src.size() != 0) ? src[0] : $urandom;
    if (cntr_out_valid && stall_left > 0) begin
      cntr_out_ready = 1'b0;
      stall_left--;
    end else begin
      cntr_out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  endtask

  // Run until every offered word is fully consumed, within a cycle budget.
  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((src.size() != 0 || exp_q.size() != 0 || cntr_out_valid || drop_pulse) && k < budget) begin
      step();
      k++;
    end
    check("drain_in_budget", 32'(k < budget), 32'd1);
  endtask

  int base_reads, base_pulses, base_acc;

  initial begin
    rst            = 1'b1;
    cntr_out_ready = 1'b1;
    src.push_back(32'hF203_2320);
    data_in        = src[0];
    data_in_valid  = 1'b1;

    // Reset held two cycles with a word pending: nothing may be acknowledged.
    step();
    step();
    check("no_ack_in_reset", 32'(n_reads), 32'd0);
    rst = 1'b0;

    // Full word twice, ready high: next acknowledge 4 cycles after the first.
    src.push_back(32'hF203_2320);
    read_cyc.delete();
    drain(50);
    check("full_reads", 32'(read_cyc.size()), 32'd2);
    if (read_cyc.size() == 2) check("full_read_gap", 32'(read_cyc[1] - read_cyc[0]), 32'd4);
    check("full_samples", 32'(n_acc), 32'd6);

    // Partial word with a 5-cycle stall.
    base_reads = n_reads; base_acc = n_acc; n_valid_cyc = 0;
    stall_left = 5;
    src.push_back(32'h4000_00C8);
    drain(50);
    check("stall_valid_cycles", 32'(n_valid_cyc), 32'd6);
    check("stall_accepts", 32'(n_acc - base_acc), 32'd1);
    check("stall_reads", 32'(n_reads - base_reads), 32'd1);

    // 260 empty words: drop counter saturates.
    base_reads = n_reads; base_pulses = n_pulses; base_acc = n_acc;
    ready_mode = 1;
    for (int i = 0; i < 260; i++) src.push_back({2'b00, 30'($urandom)});
    drain(2000);
    check("empty_pulses", 32'(n_pulses - base_pulses), 32'd260);
    check("empty_reads", 32'(n_reads - base_reads), 32'd260);
    check("empty_no_samples", 32'(n_acc - base_acc), 32'd0);
    check("drop_saturated", 32'(drop_cnt), 32'd255);

    // Reset while index=1 of a full word, then a fresh word from index 0.
    ready_mode = 0;
    src.push_back(32'hF203_2320);
    base_reads = n_reads;
    for (int k = 0; k < 20 && n_reads == base_reads; k++) step();
    check("mid_first_read", 32'(n_reads - base_reads), 32'd1);
    step();
    check("mid_index1_data", 32'(cntr_out), 32'd200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_after_rst_valid", 32'(cntr_out_valid), 32'd0);
    src.push_back(32'hF203_2320);
    drain(50);
    check("mid_drop_cleared", 32'(drop_cnt), 32'd0);

    // Streaming 17 two-sample words with random ready and valid gaps.
    base_reads = n_reads; base_acc = n_acc;
    ready_mode = 1; gap_mode = 1;
    for (int i = 0; i < 17; i++) src.push_back(mk_word(2, 200, 800, int'($urandom_range(0, 1023))));
    drain(1000);
    check("stream_reads", 32'(n_reads - base_reads), 32'd17);
    check("stream_samples", 32'(n_acc - base_acc), 32'd34);

    // Random words of every count.
    base_reads = n_reads;
    for (int i = 0; i < 60; i++) src.push_back($urandom);
    drain(3000);
    check("random_reads", 32'(n_reads - base_reads), 32'd60);
    check("model_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
